aclk_keybuf_param: RTL and testbench
====================================

Name: aclk_keybuf_param

Overview:
- Parametrised successor to the alarm-clock key register: captures keypad digits into a NUM_DIGITS-deep shift buffer, most-significant digit first.
- Adds:
  - digit count and full flag
  - backspace and clear
  - BCD key validation
  - selectable full-buffer policy
  - inactivity timeout that discards a partial entry
- Sits between the keypad scanner/debouncer and the time/alarm load logic.

Parameters:
- NUM_DIGITS, 4, number of digit slots (>=2).
- DIGIT_W, 4, bits per digit.
- MAX_DIGIT, 9, largest accepted key value; keys above it are rejected.
- LOCK_WHEN_FULL, 0: 0 = a shift into a full buffer drops the MS digit; 1 = a shift into a full buffer is rejected.
- TIMEOUT_CYCLES, 0, idle cycles after the last accepted key before auto-clear; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- key  in  DIGIT_W  digit value, sampled when shift=1.
- shift  in  1  one-cycle key-press strobe.
- backspace  in  1  one-cycle strobe: remove the most recent digit.
- clear  in  1  one-cycle strobe: empty the buffer.
- key_buffer  out  NUM_DIGITS*DIGIT_W  digits; slot NUM_DIGITS-1 (MS) occupies the top bits, slot 0 (LS, newest) the bottom bits.
- digit_count  out  $clog2(NUM_DIGITS+1)  number of valid digits entered.
- full  out  1  digit_count==NUM_DIGITS.
- key_err  out  1  one-cycle pulse: key rejected.
- timeout  out  1  one-cycle pulse: buffer auto-cleared by inactivity.

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is synchronous, active-high.
  - Reset values: key_buffer=0, digit_count=0, full=0, key_err=0, timeout=0, idle counter=0, state=EMPTY.
  - Reset overrides every other input in the same cycle; reset mid-entry discards all digits.
- All outputs are registered; the effect of a strobe is visible the cycle after it is sampled.
- Priority when strobes coincide in one cycle: clear > backspace > shift. A lower-priority strobe is ignored and produces no key_err.
- Shift, accepted when key<=MAX_DIGIT and (state!=FULL or LOCK_WHEN_FULL==0):
  - Every slot i takes slot i-1; slot 0 takes key.
  - digit_count increments, saturating at NUM_DIGITS.
  - The idle counter reloads to 0.
- Shift, rejected when key>MAX_DIGIT, or state==FULL and LOCK_WHEN_FULL==1:
  - Buffer, digit_count and idle counter are unchanged.
  - key_err=1 for one cycle.
- Backspace:
  - If digit_count>0: every slot i takes slot i+1, the MS slot takes 0, digit_count decrements, idle counter reloads.
  - If digit_count==0: no-op, no error.
- Clear:
  - Buffer=0, digit_count=0, idle counter=0. No timeout pulse.
- Timeout, only when TIMEOUT_CYCLES>0:
  - The idle counter increments each cycle while state!=EMPTY and no strobe is accepted.
  - When the counter reaches TIMEOUT_CYCLES-1, the next edge clears the buffer and count and pulses timeout for one cycle, giving a timeout exactly TIMEOUT_CYCLES idle cycles after the last accepted key.
  - An accepted strobe in that same cycle takes precedence and suppresses the timeout.
- State machine, derived from digit_count:
  - EMPTY (count 0) -> PARTIAL on an accepted shift.
  - PARTIAL -> FULL when count reaches NUM_DIGITS.
  - PARTIAL -> EMPTY on backspace to 0, clear, or timeout.
  - FULL -> PARTIAL on backspace.
  - FULL -> EMPTY on clear or timeout.
  - FULL -> FULL on a shift with LOCK_WHEN_FULL=0 (drop-oldest).
- Width rules:
  - Count and idle-counter widths are $clog2 of their maximum value plus 1.
  - No arithmetic is performed on digit values; the comparison key<=MAX_DIGIT is unsigned.

Test Plan:
- Defaults: reset, then shift keys 1,2,3,4 one cycle apart -> key_buffer=16'h1234, digit_count=4, full=1, key_err never asserted.
- From 16'h1234: LOCK_WHEN_FULL=0, shift 5 -> 16'h2345, count 4. LOCK_WHEN_FULL=1, shift 5 -> 16'h1234 unchanged, key_err pulses one cycle.
- From 16'h1234: backspace -> 16'h0123, count 3, full=0. Three more backspaces -> 0, count 0. A fifth backspace -> no change, no key_err.
- Shift key=4'hA -> buffer unchanged, key_err=1 for one cycle. Assert clear, backspace and shift with key 7 in the same cycle on 16'h0012 -> buffer 0, count 0.
- TIMEOUT_CYCLES=8: shift 7, then idle -> timeout pulses exactly 8 cycles after the shift's capture edge, buffer 0, count 0. A repeat with a shift of 3 at idle cycle 7 -> no timeout, buffer 16'h0073.
- Enter 9,8 then assert reset for one cycle while shift=1 -> all outputs 0 the next cycle. A subsequent shift 6 -> 16'h0006, count 1.

Source files
------------

// File: rtl/aclk_keybuf_param.sv
// Keypad digit buffer for the alarm clock. Digits enter at slot 0 and move
// toward slot NUM_DIGITS-1, so the first digit typed ends up most significant.
// Supports backspace, clear, key range checking, drop-oldest or lock-when-full
// behaviour, and an optional inactivity auto-clear.

// One digit slot. Each slot chooses between its shift source (the next lower
// slot, or the key for slot 0) and its backspace source (the next higher slot,
// or zero for the top slot).
module aclk_keybuf_slot #(
  parameter int DIGIT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               do_shift,
  input  logic               do_back,
  input  logic [DIGIT_W-1:0] shift_in,
  input  logic [DIGIT_W-1:0] back_in,
  output logic [DIGIT_W-1:0] q
);
  // Clear wins over shift, and shift wins over backspace. The top level never
  // raises shift and backspace together.
  always_ff @(posedge clk) begin
    if (reset || clr)  q <= '0;
    else if (do_shift) q <= shift_in;
    else if (do_back)  q <= back_in;
  end
endmodule

module aclk_keybuf_param #(
  parameter int NUM_DIGITS     = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_DIGIT      = 9,
  parameter int LOCK_WHEN_FULL = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIGIT_W-1:0]            key,
  input  logic                          shift,
  input  logic                          backspace,
  input  logic                          clear,
  output logic [NUM_DIGITS*DIGIT_W-1:0] key_buffer,
  output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count,
  output logic                          full,
  output logic                          key_err,
  output logic                          timeout
);
  localparam int CW = $clog2(NUM_DIGITS+1);
  localparam int IW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES+1) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(NUM_DIGITS);
  localparam logic [IW-1:0] IDLE_LAST = (TIMEOUT_CYCLES > 0) ? IW'(TIMEOUT_CYCLES-1) : '0;
  localparam logic [31:0]   MAX_K     = 32'(MAX_DIGIT);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] slots;
  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt_nxt;
  logic [IW-1:0] idle, idle_nxt;
  logic key_ok, lock_blk, do_back, do_shift, rej, to_fire, wipe;

  // Resolve the strobes by priority (clear > backspace > shift). A strobe that
  // loses to a higher one is simply ignored, so it raises no error.
  always_comb begin
    key_ok   = 32'(key) <= MAX_K;
    lock_blk = (LOCK_WHEN_FULL != 0) && (state == ST_FULL);
    do_back  = !clear && backspace && (digit_count != '0);
    do_shift = !clear && !backspace && shift && key_ok && !lock_blk;
    rej      = !clear && !backspace && shift && !(key_ok && !lock_blk);
    // Any accepted strobe in the final idle cycle cancels the timeout.
    to_fire  = (TIMEOUT_CYCLES > 0) && (state != ST_EMPTY) && !clear && !do_back
               && !do_shift && (idle == IDLE_LAST);
    wipe     = clear || to_fire;
  end

  // Work out the next count, state and idle counter. The state is a pure
  // function of the count.
  always_comb begin
    cnt_nxt = digit_count;
    if (wipe)          cnt_nxt = '0;
    else if (do_back)  cnt_nxt = digit_count - CW'(1);
    else if (do_shift) cnt_nxt = (digit_count == CNT_MAX) ? digit_count : digit_count + CW'(1);

    if (cnt_nxt == '0)           state_nxt = ST_EMPTY;
    else if (cnt_nxt == CNT_MAX) state_nxt = ST_FULL;
    else                         state_nxt = ST_PARTIAL;

    // A rejected key leaves the idle counter where it is.
    idle_nxt = idle;
    if (wipe || do_back || do_shift)
      idle_nxt = '0;
    else if ((TIMEOUT_CYCLES > 0) && (state != ST_EMPTY) && !rej)
      idle_nxt = idle + IW'(1);
  end

  // Registered control state and the two pulse outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_count <= '0;
      state       <= ST_EMPTY;
      full        <= 1'b0;
      key_err     <= 1'b0;
      timeout     <= 1'b0;
      idle        <= '0;
    end else begin
      digit_count <= cnt_nxt;
      state       <= state_nxt;
      full        <= (state_nxt == ST_FULL);
      key_err     <= rej;
      timeout     <= to_fire;
      idle        <= idle_nxt;
    end
  end

  // Each slot gets its shift and backspace sources from its neighbours.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_slot
    logic [DIGIT_W-1:0] s_in, b_in;
    if (g == 0) begin : g_lo
      assign s_in = key;
    end else begin : g_mid
      assign s_in = slots[g-1];
    end
    if (g == NUM_DIGITS-1) begin : g_hi
      assign b_in = '0;
    end else begin : g_nhi
      assign b_in = slots[g+1];
    end
    aclk_keybuf_slot #(.DIGIT_W(DIGIT_W)) u_slot (
      .clk      (clk),
      .reset    (reset),
      .clr      (wipe),
      .do_shift (do_shift),
      .do_back  (do_back),
      .shift_in (s_in),
      .back_in  (b_in),
      .q        (slots[g])
    );
  end

  assign key_buffer = slots;
endmodule

// File: tb/tb_aclk_keybuf_param.sv
// Bench for aclk_keybuf_param. Three instances share the same stimulus:
// the default configuration, lock-when-full, and an 8-cycle timeout. The
// stimulus pushes hand-computed expected snapshots into a queue, and a
// monitor on the falling edge pops them and compares.
module tb_aclk_keybuf_param;
  logic clk = 1'b0;
  logic reset = 1'b0, shift = 1'b0, backspace = 1'b0, clear = 1'b0;
  logic [3:0] key = '0;

  logic [15:0] kb   [3];
  logic [2:0]  cnt  [3];
  logic        full [3];
  logic        err  [3];
  logic        to   [3];

  typedef struct {
    int          stamp;
    int          id;
    logic [15:0] kb;
    logic [2:0]  cnt;
    logic        full, err, to;
  } exp_t;
  exp_t sbq[$];

  int ecnt = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  aclk_keybuf_param u_def (
    .clk(clk), .reset(reset), .key(key), .shift(shift), .backspace(backspace), .clear(clear),
    .key_buffer(kb[0]), .digit_count(cnt[0]), .full(full[0]), .key_err(err[0]), .timeout(to[0]));
  aclk_keybuf_param #(.LOCK_WHEN_FULL(1)) u_lock (
    .clk(clk), .reset(reset), .key(key), .shift(shift), .backspace(backspace), .clear(clear),
    .key_buffer(kb[1]), .digit_count(cnt[1]), .full(full[1]), .key_err(err[1]), .timeout(to[1]));
  aclk_keybuf_param #(.TIMEOUT_CYCLES(8)) u_to (
    .clk(clk), .reset(reset), .key(key), .shift(shift), .backspace(backspace), .clear(clear),
    .key_buffer(kb[2]), .digit_count(cnt[2]), .full(full[2]), .key_err(err[2]), .timeout(to[2]));

  // Monitor: compare every expected entry that is due for this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0 && sbq[0].stamp <= ecnt) begin
      e = sbq.pop_front();
      n_checks++;
      if ({kb[e.id], cnt[e.id], full[e.id], err[e.id], to[e.id]} !==
          {e.kb, e.cnt, e.full, e.err, e.to}) begin
        n_errors++;
        $display("FAIL dut%0d @edge %0d: got buf=%h cnt=%0d full=%b err=%b to=%b, want buf=%h cnt=%0d full=%b err=%b to=%b",
                 e.id, e.stamp, kb[e.id], cnt[e.id], full[e.id], err[e.id], to[e.id],
                 e.kb, e.cnt, e.full, e.err, e.to);
      end
    end
  end

  // Present the inputs for one clock edge, then return to idle just after it.
  task automatic step(input logic r, input logic s, input logic [3:0] k,
                      input logic b, input logic c);
    reset = r; shift = s; key = k; backspace = b; clear = c;
    @(posedge clk);
    #1;
    reset = 1'b0; shift = 1'b0; backspace = 1'b0; clear = 1'b0;
  endtask

  task automatic exp(input int id, input logic [15:0] b, input logic [2:0] c,
                     input logic f, input logic e, input logic t);
    exp_t x;
    x.stamp = ecnt; x.id = id; x.kb = b; x.cnt = c; x.full = f; x.err = e; x.to = t;
    sbq.push_back(x);
  endtask

  task automatic idle(); step(0, 0, 4'h0, 0, 0); endtask
  task automatic sh(input logic [3:0] k); step(0, 1, k, 0, 0); endtask

  initial begin
    // Reset, then key in 1,2,3,4.
    step(1, 0, 4'h0, 0, 0);
    for (int i = 0; i < 3; i++) exp(i, 16'h0000, 3'd0, 0, 0, 0);
    sh(4'h1); exp(0, 16'h0001, 3'd1, 0, 0, 0);
    sh(4'h2); exp(0, 16'h0012, 3'd2, 0, 0, 0);
    sh(4'h3); exp(0, 16'h0123, 3'd3, 0, 0, 0);
    sh(4'h4); exp(0, 16'h1234, 3'd4, 1, 0, 0); exp(1, 16'h1234, 3'd4, 1, 0, 0);

    // Shifting into a full buffer: drop-oldest versus locked.
    sh(4'h5); exp(0, 16'h2345, 3'd4, 1, 0, 0); exp(1, 16'h1234, 3'd4, 1, 1, 0);
    idle();   exp(1, 16'h1234, 3'd4, 1, 0, 0);

    // Backspace down to empty, then one more.
    step(1, 0, 4'h0, 0, 0);
    sh(4'h1); sh(4'h2); sh(4'h3); sh(4'h4);
    step(0, 0, 4'h0, 1, 0); exp(0, 16'h0123, 3'd3, 0, 0, 0);
    step(0, 0, 4'h0, 1, 0); exp(0, 16'h0012, 3'd2, 0, 0, 0);
    step(0, 0, 4'h0, 1, 0); exp(0, 16'h0001, 3'd1, 0, 0, 0);
    step(0, 0, 4'h0, 1, 0); exp(0, 16'h0000, 3'd0, 0, 0, 0);
    step(0, 0, 4'h0, 1, 0); exp(0, 16'h0000, 3'd0, 0, 0, 0);

    // An out-of-range key, then clear/backspace/shift all in one cycle.
    sh(4'hA); exp(0, 16'h0000, 3'd0, 0, 1, 0);
    idle();   exp(0, 16'h0000, 3'd0, 0, 0, 0);
    sh(4'h1); sh(4'h2); exp(0, 16'h0012, 3'd2, 0, 0, 0);
    step(0, 1, 4'h7, 1, 1); exp(0, 16'h0000, 3'd0, 0, 0, 0);

    // Timeout after 8 idle cycles, then a key on the last idle cycle.
    step(1, 0, 4'h0, 0, 0);
    sh(4'h7); exp(2, 16'h0007, 3'd1, 0, 0, 0);
    for (int i = 1; i <= 7; i++) begin idle(); exp(2, 16'h0007, 3'd1, 0, 0, 0); end
    idle(); exp(2, 16'h0000, 3'd0, 0, 0, 1);
    idle(); exp(2, 16'h0000, 3'd0, 0, 0, 0);
    sh(4'h7);
    for (int i = 1; i <= 7; i++) idle();
    sh(4'h3); exp(2, 16'h0073, 3'd2, 0, 0, 0);
    idle();   exp(2, 16'h0073, 3'd2, 0, 0, 0);

    // Reset in the middle of an entry, with shift raised in the same cycle.
    step(1, 0, 4'h0, 0, 0);
    sh(4'h9); sh(4'h8); exp(0, 16'h0098, 3'd2, 0, 0, 0);
    step(1, 1, 4'h5, 0, 0);
    for (int i = 0; i < 3; i++) exp(i, 16'h0000, 3'd0, 0, 0, 0);
    sh(4'h6); exp(0, 16'h0006, 3'd1, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (sbq.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, want 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want normal finish");
    $fatal(1, "watchdog");
  end
endmodule
